// File: rtl/fetch_unit.sv
// Purpose: instruction fetch front end; owns the PC, reads the ROM, and queues {pc, instr} pairs for decode.
// Latency: a PC presented in cycle N appears at the queue head in cycle N+1; a redirect in N gives imem_address=redirect_pc in N+1.
// Backpressure: fetch_valid/fetch_ready at the head; a full queue holds the PC until a slot frees (push with a simultaneous pop is allowed).
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   imem_address / imem_instruction   fetch PC to the ROM, same-cycle read data back
//   redirect_valid / redirect_pc      flush the queue and re-steer the PC
//   fetch_valid / fetch_ready / fetch_instruction / fetch_pc   queue head handshake to decode
//   fetch_halted                 fetch stopped at a misaligned or out-of-range PC
//   queue_count                  occupied queue entries
module fetch_unit #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [63:0] RESET_PC    = 64'd0,
  parameter int          IMEM_SIZE   = 1024
) (
  input  logic                           clk,
  input  logic                           reset_n,
  output logic [63:0]                    imem_address,
  input  logic [31:0]                    imem_instruction,
  input  logic                           redirect_valid,
  input  logic [63:0]                    redirect_pc,
  output logic                           fetch_valid,
  input  logic                           fetch_ready,
  output logic [31:0]                    fetch_instruction,
  output logic [63:0]                    fetch_pc,
  output logic                           fetch_halted,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [63:0]   pc;
  logic          halted;
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] count;
  entry_t        q_mem [QUEUE_DEPTH];

  logic [64:0]   pc_last_byte;
  logic          bad_pc;
  logic          full;
  logic          pop;
  logic          push;

  // Last byte of the word at pc, widened so a PC near 2^64 cannot wrap into range.
  assign pc_last_byte = {1'b0, pc} + 65'd3;
  assign bad_pc       = (pc[1:0] != 2'b00) || (pc_last_byte >= 65'(IMEM_SIZE));
  assign full         = (count == CW'(QUEUE_DEPTH));

  assign pop  = fetch_valid && fetch_ready;
  // A pop in the same cycle frees the slot, so a full queue still sustains one per cycle.
  assign push = !halted && !redirect_valid && !bad_pc && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= RESET_PC;
      halted <= 1'b0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q_mem[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Redirect wins over everything; a same-cycle pop is squashed by decode.
      pc     <= redirect_pc;
      halted <= 1'b0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        head <= head + PW'(1);
      end
      if (push) begin
        q_mem[tail] <= '{pc: pc, instr: imem_instruction};
        tail        <= tail + PW'(1);
        pc          <= pc + 64'd4;
      end
      if (!halted && bad_pc) begin
        halted <= 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  assign imem_address      = pc;
  assign fetch_valid       = (count != '0);
  assign fetch_instruction = q_mem[head].instr;
  assign fetch_pc          = q_mem[head].pc;
  assign fetch_halted      = halted;
  assign queue_count       = count;

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam int          MEM_SIZE = 1024;
  localparam logic [63:0] BOOT_PC  = 64'd0;

  logic        clk;
  logic        reset_n;
  logic [63:0] imem_address;
  logic [31:0] imem_instruction;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        fetch_valid;
  logic        fetch_ready;
  logic [31:0] fetch_instruction;
  logic [63:0] fetch_pc;
  logic        fetch_halted;
  logic [2:0]  queue_count;

  int checks;
  int failures;

  // Reference model: a queue of expected {pc, instr}, the fetch PC and the halt flag.
  logic [63:0] mq_pc[$];
  logic [31:0] mq_ins[$];
  logic [63:0] mpc;
  logic        mhalted;

  fetch_unit #(.QUEUE_DEPTH(DEPTH), .RESET_PC(BOOT_PC), .IMEM_SIZE(MEM_SIZE)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .imem_address      (imem_address),
    .imem_instruction  (imem_instruction),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .fetch_valid       (fetch_valid),
    .fetch_ready       (fetch_ready),
    .fetch_instruction (fetch_instruction),
    .fetch_pc          (fetch_pc),
    .fetch_halted      (fetch_halted),
    .queue_count       (queue_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM word k holds A000_0000 + k.
  function automatic logic [31:0] rom_word(input logic [63:0] a);
    logic [63:0] k;
    k = a >> 2;
    return 32'hA000_0000 + k[31:0];
  endfunction

  assign imem_instruction = rom_word(imem_address);

  function automatic bit model_bad(input logic [63:0] a);
    return (a % 4 != 0) || (a > 64'(MEM_SIZE - 4));
  endfunction

  task automatic model_reset();
    mq_pc.delete();
    mq_ins.delete();
    mpc     = BOOT_PC;
    mhalted = 1'b0;
  endtask

  task automatic model_clock(input bit rv, input logic [63:0] rpc, input bit rdy);
    bit popped;
    popped = (mq_pc.size() != 0) && rdy;
    if (rv) begin
      mq_pc.delete();
      mq_ins.delete();
      mpc     = rpc;
      mhalted = 1'b0;
    end else begin
      if (popped) begin
        void'(mq_pc.pop_front());
        void'(mq_ins.pop_front());
      end
      if (!mhalted) begin
        if (model_bad(mpc)) begin
          mhalted = 1'b1;
        end else if (mq_pc.size() < DEPTH) begin
          mq_pc.push_back(mpc);
          mq_ins.push_back(rom_word(mpc));
          mpc = mpc + 64'd4;
        end
      end
    end
  endtask

  // Drive inputs, clock once, advance the model, then settle to the sampling point.
  task automatic drive_cycle(input bit rv, input logic [63:0] rpc, input bit rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    fetch_ready    = rdy;
    @(posedge clk);
    model_clock(rv, rpc, rdy);
    #1;
  endtask

  task automatic test_reset();
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    fetch_ready    = 1'b0;
    model_reset();
    #3;
    checks++;
    if (fetch_valid !== 1'b0 || queue_count !== 3'd0 || fetch_halted !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: valid=%b count=%0d halted=%b, want 0/0/0", fetch_valid, queue_count, fetch_halted);
    end
    checks++;
    if (imem_address !== BOOT_PC || fetch_pc !== 64'd0 || fetch_instruction !== 32'd0) begin
      failures++;
      $display("FAIL reset_data: addr=%h pc=%h instr=%h, want %h/0/0", imem_address, fetch_pc, fetch_instruction, BOOT_PC);
    end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    for (int k = 1; k <= 8; k++) begin
      drive_cycle(1'b0, '0, 1'b1);
      checks++;
      if (fetch_valid !== 1'b1 || fetch_pc !== 64'(4 * (k - 1)) || fetch_instruction !== 32'hA000_0000 + 32'(k - 1)) begin
        failures++;
        $display("FAIL stream[%0d]: valid=%b pc=%h instr=%h, want 1/%h/%h", k, fetch_valid, fetch_pc, fetch_instruction,
                 64'(4 * (k - 1)), 32'hA000_0000 + 32'(k - 1));
      end
    end
  endtask

  task automatic test_backpressure();
    drive_cycle(1'b1, 64'd0, 1'b1);
    for (int i = 0; i < 10; i++) drive_cycle(1'b0, '0, 1'b0);
    checks++;
    if (queue_count !== 3'd4 || imem_address !== 64'd16) begin
      failures++;
      $display("FAIL bp_stall: count=%0d addr=%h, want 4/10", queue_count, imem_address);
    end
    checks++;
    if (fetch_pc !== 64'd0) begin
      failures++;
      $display("FAIL bp_head: pc=%h, want 0", fetch_pc);
    end
    for (int j = 1; j <= 8; j++) begin
      drive_cycle(1'b0, '0, 1'b1);
      checks++;
      if (fetch_pc !== 64'(4 * j) || fetch_instruction !== 32'hA000_0000 + 32'(j) || queue_count !== 3'd4) begin
        failures++;
        $display("FAIL bp_drain[%0d]: pc=%h instr=%h count=%0d, want %h/%h/4", j, fetch_pc, fetch_instruction, queue_count,
                 64'(4 * j), 32'hA000_0000 + 32'(j));
      end
    end
  endtask

  task automatic test_redirect_full();
    // Queue is full here and fetch_ready=1, so the redirect coincides with a pop.
    drive_cycle(1'b1, 64'h100, 1'b1);
    checks++;
    if (queue_count !== 3'd0 || fetch_valid !== 1'b0 || imem_address !== 64'h100) begin
      failures++;
      $display("FAIL redir_flush: count=%0d valid=%b addr=%h, want 0/0/100", queue_count, fetch_valid, imem_address);
    end
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== 64'h100 || fetch_instruction !== 32'hA000_0040) begin
      failures++;
      $display("FAIL redir_first: valid=%b pc=%h instr=%h, want 1/100/a0000040", fetch_valid, fetch_pc, fetch_instruction);
    end
  endtask

  task automatic test_end_of_mem();
    logic [63:0] seen[$];
    drive_cycle(1'b1, 64'd1016, 1'b1);
    for (int i = 0; i < 8; i++) begin
      drive_cycle(1'b0, '0, 1'b1);
      if (fetch_valid === 1'b1) seen.push_back(fetch_pc);
    end
    checks++;
    if (seen.size() != 2 || seen[0] !== 64'd1016 || seen[1] !== 64'd1020) begin
      failures++;
      $display("FAIL eom_delivered: count=%0d first=%h, want 2 entries 3f8,3fc", seen.size(), (seen.size() > 0) ? seen[0] : 64'hx);
    end
    checks++;
    if (fetch_halted !== 1'b1 || imem_address !== 64'd1024 || queue_count !== 3'd0) begin
      failures++;
      $display("FAIL eom_halt: halted=%b addr=%h count=%0d, want 1/400/0", fetch_halted, imem_address, queue_count);
    end
    drive_cycle(1'b1, 64'd0, 1'b1);
    checks++;
    if (fetch_halted !== 1'b0 || imem_address !== 64'd0) begin
      failures++;
      $display("FAIL eom_clear: halted=%b addr=%h, want 0/0", fetch_halted, imem_address);
    end
  endtask

  task automatic test_misaligned();
    drive_cycle(1'b1, 64'h6, 1'b1);
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (fetch_halted !== 1'b1 || queue_count !== 3'd0 || fetch_valid !== 1'b0 || imem_address !== 64'h6) begin
      failures++;
      $display("FAIL misaligned: halted=%b count=%0d valid=%b addr=%h, want 1/0/0/6", fetch_halted, queue_count, fetch_valid,
               imem_address);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(1'b1, 64'h40, 1'b1);
    for (int i = 0; i < 3; i++) drive_cycle(1'b0, '0, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (fetch_valid !== 1'b0 || queue_count !== 3'd0 || fetch_halted !== 1'b0 || imem_address !== BOOT_PC ||
        fetch_pc !== 64'd0 || fetch_instruction !== 32'd0) begin
      failures++;
      $display("FAIL async_reset: valid=%b count=%0d halted=%b addr=%h pc=%h instr=%h, want all reset values", fetch_valid,
               queue_count, fetch_halted, imem_address, fetch_pc, fetch_instruction);
    end
    reset_n = 1'b1;
    drive_cycle(1'b0, '0, 1'b1);
    checks++;
    if (fetch_valid !== 1'b1 || fetch_pc !== BOOT_PC || fetch_instruction !== rom_word(BOOT_PC)) begin
      failures++;
      $display("FAIL restart: valid=%b pc=%h instr=%h, want 1/%h", fetch_valid, fetch_pc, fetch_instruction, BOOT_PC);
    end
  endtask

  task automatic test_random();
    logic [63:0] rpc;
    bit          rv;
    bit          rdy;
    int          bad_cycles;
    bad_cycles = 0;
    for (int c = 0; c < 400; c++) begin
      rv  = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 5))
        0:       rpc = 64'(MEM_SIZE - 4 * $urandom_range(1, 4));
        1:       rpc = 64'(4 * $urandom_range(0, 255) + $urandom_range(1, 3));
        2:       rpc = 64'hFFFF_FFFF_FFFF_FFFC;
        3:       rpc = 64'(MEM_SIZE + 4 * $urandom_range(0, 8));
        default: rpc = 64'(4 * $urandom_range(0, 255));
      endcase
      drive_cycle(rv, rpc, rdy);
      if ((fetch_valid !== (mq_pc.size() != 0)) || (queue_count !== 3'(mq_pc.size())) || (imem_address !== mpc) ||
          (fetch_halted !== mhalted) ||
          ((mq_pc.size() != 0) && (fetch_pc !== mq_pc[0] || fetch_instruction !== mq_ins[0]))) begin
        bad_cycles++;
        if (bad_cycles <= 5)
          $display("FAIL rand[%0d]: valid=%b count=%0d addr=%h halted=%b pc=%h instr=%h, want count=%0d addr=%h halted=%b pc=%h",
                   c, fetch_valid, queue_count, imem_address, fetch_halted, fetch_pc, fetch_instruction, mq_pc.size(), mpc,
                   mhalted, (mq_pc.size() != 0) ? mq_pc[0] : 64'h0);
      end
      checks++;
      if (bad_cycles != 0 && c == 399) failures++;
    end
    checks++;
    if (bad_cycles != 0) begin
      failures++;
      $display("FAIL rand_total: %0d mismatching cycles, want 0", bad_cycles);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_full();
    test_end_of_mem();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch front end for the out-of-order core. It owns the program counter and drives word addresses into the combinational instruction ROM. Each returned instruction is captured together with its PC into a small in-order fetch queue, and the queue drains to decode through a valid/ready handshake. The block stalls when the queue is full, stops cleanly at the end of instruction memory, and flushes and re-steers on a redirect from branch resolution.

## Interface
Parameters:
- QUEUE_DEPTH, 4: number of fetch queue entries. Must be a power of two and ≥2.
- RESET_PC, 64'd0: PC loaded at reset. Must be word-aligned.
- IMEM_SIZE, 1024: instruction memory size in bytes. Must be a power of two.

Ports:
- clk  in  1  clock. All state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- imem_address  out  64  byte address of the current fetch PC, driven directly from the PC register.
- imem_instruction  in  32  ROM read data, combinational from imem_address in the same cycle.
- redirect_valid  in  1  flush and re-steer request from branch resolution.
- redirect_pc  in  64  new fetch PC, sampled when redirect_valid=1.
- fetch_valid  out  1  queue head holds a valid entry.
- fetch_ready  in  1  decode accepts the head entry.
- fetch_instruction  out  32  instruction at the queue head.
- fetch_pc  out  64  PC of the queue head entry.
- fetch_halted  out  1  fetch has stopped at an out-of-range or misaligned PC.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  number of occupied entries.

## Operation
- State:
  - pc (64b)
  - halted flag
  - circular queue: head and tail pointers of width $clog2(QUEUE_DEPTH), plus a count register
  - storage entries of {pc, instr}
- Reset (async assert, sync deassert):
  - pc=RESET_PC; head, tail and count = 0; halted=0; all storage = 0.
  - Outputs during reset: fetch_valid=0, fetch_instruction=0, fetch_pc=0, fetch_halted=0, queue_count=0, imem_address=RESET_PC.
- pop = fetch_valid & fetch_ready.
- push = ~halted & ~redirect_valid & ~bad_pc & (count<QUEUE_DEPTH | pop).
  - bad_pc = (pc[1:0]!=0) | (pc+3 >= IMEM_SIZE). Compute the sum in 65 bits so it cannot wrap.
  - On push: write {pc, imem_instruction} at tail; tail wraps modulo QUEUE_DEPTH; pc += 4.
- Halt: on a cycle where ~halted & ~redirect_valid & bad_pc, set halted=1. pc holds its value and nothing is pushed. Queued entries continue to drain normally.
- Redirect (highest priority):
  - count=0; head=tail=0; pc=redirect_pc; halted=0.
  - No push occurs. Any pop in the same cycle is discarded, so decode must treat that entry as squashed.
  - A misaligned or out-of-range redirect_pc is legal. It causes a halt on the next cycle.
- count update:
  - +1 on push only
  - −1 on pop only
  - unchanged when push and pop occur together
  - 0 on redirect
- fetch_valid = (count!=0). fetch_instruction and fetch_pc read the storage entry at head.
- Stall: while the queue is full and fetch_ready=0, pc and imem_address hold. Nothing is lost: the same address is re-presented until it is accepted.

## Timing
- imem_address changes only at posedge. The ROM read is combinational, and the instruction is captured at the next posedge.
- Latency, empty queue: the PC is presented in cycle N, and fetch_valid=1 with that PC/instruction in cycle N+1.
- Throughput: one instruction per cycle sustained while fetch_ready=1, including when the queue is full and a pop occurs (push on full with simultaneous pop is allowed).
- Redirect: asserted in cycle N. In cycle N+1, imem_address=redirect_pc and fetch_valid=0. The first redirected entry is valid in cycle N+2.
- No combinational path from fetch_ready or redirect_valid to fetch_valid, fetch_instruction or fetch_pc. The only combinational input-to-output path is imem_address → imem_instruction, which is external.
- fetch_halted is registered and rises one cycle after bad_pc is first seen.

## Test plan
- Reset/stream: RESET_PC=0, ROM word k = 32'hA000_0000+k, fetch_ready=1 → fetch_pc = 0, 4, 8, … on consecutive cycles from cycle 1, with matching instructions and no gaps.
- Backpressure: hold fetch_ready=0 for 10 cycles → queue_count saturates at 4 and imem_address holds at 16. Release → entries drain in order with PCs 0, 4, 8, 12, 16, 20, …; none dropped or duplicated.
- Redirect with full queue and simultaneous pop: redirect_pc=64'h100 → next cycle queue_count=0 and fetch_valid=0; the following cycle fetch_pc=64'h100.
- End of memory: RESET_PC=1016, IMEM_SIZE=1024 → PCs 1016 and 1020 are delivered, PC 1024 is never queued, and fetch_halted=1 while imem_address stays at 1024. A subsequent redirect to 0 clears the halt.
- Misaligned redirect_pc=64'h6 → no push and fetch_halted=1 on the next cycle.
- Async reset mid-stream (reset_n low between clock edges) → all outputs immediately take reset values. After release, fetch restarts at RESET_PC.
